memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port 512x32 RAM (sync read, 1-cycle latency).
//  Shares the RAM between port 0 (CPU MAR/MDR path) and port 1 (I/O / DMA loader).
//  Each request is a full transaction; the block drives RAM read/write/address, captures read data, returns an ack.
// PARAMETERS
//  ADDR_W          9   RAM address width
//  DATA_W          32  RAM data width
//  FIXED_PRIORITY  0   1 = port 0 always wins ties; 0 = round-robin on ties
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       asynchronous, active-low reset
//  p0_req        in   1       port 0 request; held high until p0_ack
//  p0_we         in   1       port 0: 1 = write, 0 = read
//  p0_addr       in   ADDR_W  port 0 address
//  p0_wdata      in   DATA_W  port 0 write data
//  p0_ack        out  1       port 0 one-cycle completion pulse
//  p0_rdata      out  DATA_W  port 0 read data, valid while p0_ack=1 and held until next p0 read
//  p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rdata   same as port 0, for port 1
//  mem_read      out  1       RAM read strobe
//  mem_write     out  1       RAM write strobe
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_rdata     in   DATA_W  RAM data output (X when RAM read was low)
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; mem_read/mem_write/acks/busy=0; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; last_grant=1.
//  All outputs registered; no combinational path from inputs to outputs.
//  FSM states IDLE, ACCESS, WAIT, RESP:
//   IDLE:   if any req sampled high -> pick winner; latch winner id, we, addr, wdata -> ACCESS.
//           mem_addr/mem_wdata load from winner; mem_read=!we or mem_write=we set for ACCESS.
//   ACCESS: exactly one of mem_read/mem_write high for exactly this one cycle.
//           Write -> RESP. Read -> WAIT.
//   WAIT:   strobes low; mem_rdata valid this cycle; at the closing edge, winner rdata <= mem_rdata -> RESP.
//   RESP:   winner ack=1 for this one cycle; last_grant <= winner -> IDLE.
//  mem_rdata is sampled only at the WAIT->RESP edge; X at any other time is legal and is ignored.
//  mem_addr/mem_wdata hold their value outside ACCESS; no strobe is ever high in IDLE, WAIT or RESP.
//  Latency (req first sampled at edge E0): write ack high in cycle after E1; read ack high in cycle after E2.
//  Throughput: one write per 3 cycles, one read per 4 cycles (IDLE cycle between transactions).
//  Arbitration, only in IDLE:
//   Single request: grant it.
//   Both requesting: FIXED_PRIORITY=1 -> port 0. FIXED_PRIORITY=0 -> port != last_grant.
//   Loser keeps req high and is served next; no starvation in round-robin mode.
//  Requester rules: addr/we/wdata are latched at grant, so later changes do not affect the transaction.
//   req still high in the cycle after ack counts as a new request.
//   req dropped before ack: the transaction still completes and the ack still pulses.
//  Width: addresses pass through unmodified; no wrap or range check (ADDR_W matches the RAM).
//  Reset mid-operation: FSM returns to IDLE at once, no ack is issued.
//   A write is committed to RAM only if the ACCESS closing edge occurred before reset.
// TESTING
//  1. Reset: hold reset_n=0 with random inputs -> all outputs 0, busy=0; release -> IDLE, no strobes.
//  2. p0 write 0xDEADBEEF @0x010 -> mem_write=1 for exactly 1 cycle, addr 0x010.
//     p0_ack 2 cycles after req sampled; p0 read @0x010 -> p0_rdata=0xDEADBEEF, ack 3 cycles after req.
//  3. p0 and p1 both read (0x001, 0x002) from reset, round-robin -> p0 served first, then p1.
//     Both held continuously -> grants alternate p0,p1,p0,p1 over 4 transactions.
//  4. FIXED_PRIORITY=1 with both reqs held -> p0 always granted; p1 granted only after p0_req drops.
//  5. p1 changes addr/wdata mid-transaction and drops req in WAIT -> original values used, p1_ack still pulses once.
//  6. Assert reset_n=0 during WAIT of a p1 read -> no p1_ack, outputs 0.
//     Write issued, then reset during its RESP -> data present in RAM on readback.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port arbiter/sequencer in front of a single-port sync-read RAM.
// Runs one full transaction at a time: IDLE -> ACCESS -> (WAIT for reads) -> RESP -> IDLE.
module memory_arbiter #(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 32,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic win_q, win_d, last_q, last_d, pick1;
   logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d, busy_q, busy_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

   // Port 1 wins alone, or on a tie when round-robin says port 0 was served last.
   assign pick1 = p1_req && (!p0_req || (!FIXED_PRIORITY && !last_q));

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
      p0_ack_d    = 1'b0;
      p1_ack_d    = 1'b0;
      case (state_q)
         IDLE: if (p0_req || p1_req) begin
            state_d     = ACCESS;
            win_d       = pick1;
            mem_addr_d  = pick1 ? p1_addr : p0_addr;
            mem_wdata_d = pick1 ? p1_wdata : p0_wdata;
            mem_write_d = pick1 ? p1_we : p0_we;
            mem_read_d  = !mem_write_d;
         end
         // The registered write strobe doubles as the latched we of the granted request.
         ACCESS: begin
            state_d  = mem_write_q ? RESP : WAIT;
            p0_ack_d = mem_write_q && !win_q;
            p1_ack_d = mem_write_q && win_q;
         end
         WAIT: begin
            state_d    = RESP;
            p0_rdata_d = win_q ? p0_rdata_q : mem_rdata;
            p1_rdata_d = win_q ? mem_rdata : p1_rdata_q;
            p0_ack_d   = !win_q;
            p1_ack_d   = win_q;
         end
         default: begin
            state_d = IDLE;
            last_d  = win_q;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         last_q      <= 1'b1;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         last_q      <= last_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
         p0_ack_q    <= p0_ack_d;
         p1_ack_q    <= p1_ack_d;
         busy_q      <= busy_d;
      end
   end

   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
endmodule
